// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, matrix geometry and the FSM state encoding
// used by both directions of the matrix link.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned ROWS  = 2;
  localparam int unsigned COLS  = 4;
  localparam int unsigned CELLS = ROWS * COLS;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Mode 3 (and anything larger) behaves as no parity.
  function automatic bit par_enabled(int unsigned mode);
    return (mode != PAR_NONE) && (mode <= PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the idle-high serial line; resets to 1 so reset
// never looks like a start edge.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_matrix.sv
// UART receiver filling a 2x4 byte matrix in arrival order, read back by row/col.
// Define UART_RX_ERR_EN to compile the sticky parity/stop error flag.
module uart_rx_matrix
  import uart_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned PAR      = 0,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         row,
  input  logic [1:0]   col,
  output logic [W-1:0] r_cell,
  output logic         r_busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam bit HasPar = par_enabled(PAR);

  localparam logic [CW-1:0] HalfLast = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BitLast  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DataLast = BW'(W - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [W-1:0]  shift_q;
  logic [2:0]    idx_q;
  logic [W-1:0]  mem_q [CELLS];
  logic          busy_q;
  logic          done_q;

`ifdef UART_RX_ERR_EN
  logic err_q;
  logic par_exp;

  assign par_exp = (PAR == PAR_ODD) ? ~^shift_q : ^shift_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < CELLS; i++) begin
        mem_q[i] <= '0;
      end
`ifdef UART_RX_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_q + CW'(1);
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          // Mid-bit check rejects glitches shorter than half a bit.
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              if (idx_q == 3'd0) begin
                busy_q <= 1'b1;
`ifdef UART_RX_ERR_EN
                err_q  <= 1'b0;
`endif
              end
            end
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[W-1:1]};
            bit_q   <= bit_q + BW'(1);
            if (bit_q == DataLast) begin
              state_q <= HasPar ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= StStop;
`ifdef UART_RX_ERR_EN
            if (rx_s != par_exp) begin
              err_q <= 1'b1;
            end
`endif
          end
        end
        StStop: begin
          // Bad frames are still stored so the matrix order is never disturbed.
          if (cnt_q == BitLast) begin
            cnt_q        <= '0;
            state_q      <= StIdle;
            mem_q[idx_q] <= shift_q;
            idx_q        <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
`ifdef UART_RX_ERR_EN
            if (!rx_s) begin
              err_q <= 1'b1;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r_cell = mem_q[{row, col}];
  assign r_busy = busy_q;
  assign done   = done_q;

`ifdef UART_RX_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_matrix.sv
// Randomised bench for uart_rx_matrix: two instances (even and odd parity) checked
// against a frame-level model of the matrix contents, index, busy, done and err.
module tb_uart_rx_matrix;

  localparam int unsigned W = 8;
  localparam int unsigned B = 4;

`ifdef UART_RX_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_a;
  logic         rx_b;
  logic         row;
  logic [1:0]   col;
  logic [W-1:0] cell_a;
  logic [W-1:0] cell_b;
  logic         busy_a;
  logic         busy_b;
  logic         done_a;
  logic         done_b;
  logic         err_a;
  logic         err_b;

  always #5 clk = ~clk;

  uart_rx_matrix #(.W(W), .PAR(2), .BAUD_DIV(B)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx_a),
    .row    (row),
    .col    (col),
    .r_cell (cell_a),
    .r_busy (busy_a),
    .done   (done_a),
    .err    (err_a)
  );

  uart_rx_matrix #(.W(W), .PAR(1), .BAUD_DIV(B)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx_b),
    .row    (row),
    .col    (col),
    .r_cell (cell_b),
    .r_busy (busy_b),
    .done   (done_b),
    .err    (err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: instance 0 is even parity, instance 1 is odd parity.
  logic [W-1:0] m_mem  [2][8];
  int           m_idx  [2];
  bit           m_busy [2];
  bit           m_err  [2];
  int           m_done [2];

  // Done monitor: pulse count plus violations (wider than one cycle, or busy still high).
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  int   done_bad_a = 0;
  int   done_bad_b = 0;
  logic done_prev_a = 1'b0;
  logic done_prev_b = 1'b0;

  always @(negedge clk) begin
    done_prev_a <= done_a;
    done_prev_b <= done_b;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      if (busy_a || done_prev_a) done_bad_a <= done_bad_a + 1;
    end
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      if (busy_b || done_prev_b) done_bad_b <= done_bad_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic drive_bit(input int inst, input logic v);
    set_rx(inst, v);
    repeat (B) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 8; c++) m_mem[i][c] = '0;
      m_idx[i]  = 0;
      m_busy[i] = 1'b0;
      m_err[i]  = 1'b0;
    end
  endtask

  task automatic do_reset(input int hold);
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_frame(input int inst, input logic [W-1:0] data, input bit par_ok,
                            input bit stop_ok);
    bit par_bit;
    // Even parity bit makes the total ones count even; odd parity is its inverse.
    par_bit = (($countones(data) % 2) == 1) ^ (inst == 1);
    if (!par_ok) par_bit = !par_bit;
    drive_bit(inst, 1'b0);
    for (int k = 0; k < W; k++) drive_bit(inst, data[k]);
    drive_bit(inst, par_bit);
    drive_bit(inst, stop_ok);
    set_rx(inst, 1'b1);
    if (m_idx[inst] == 0) begin
      m_busy[inst] = 1'b1;
      m_err[inst]  = 1'b0;
    end
    m_mem[inst][m_idx[inst]] = data;
    if (ErrEn && (!par_ok || !stop_ok)) m_err[inst] = 1'b1;
    if (m_idx[inst] == 7) begin
      m_busy[inst] = 1'b0;
      m_done[inst]++;
    end
    m_idx[inst] = (m_idx[inst] + 1) % 8;
    repeat (2 + $urandom_range(0, 2) + (stop_ok ? 0 : B)) @(negedge clk);
  endtask

  task automatic check_status(input int inst, input string what);
    if (inst == 0) begin
      check({what, ".busy_a"}, busy_a, m_busy[0]);
      check({what, ".err_a"}, err_a, m_err[0]);
      check({what, ".done_cnt_a"}, done_cnt_a, m_done[0]);
      check({what, ".done_bad_a"}, done_bad_a, 0);
    end else begin
      check({what, ".busy_b"}, busy_b, m_busy[1]);
      check({what, ".err_b"}, err_b, m_err[1]);
      check({what, ".done_cnt_b"}, done_cnt_b, m_done[1]);
      check({what, ".done_bad_b"}, done_bad_b, 0);
    end
  endtask

  task automatic check_cells(input int inst, input string what);
    logic [2:0] a;
    for (int i = 0; i < 8; i++) begin
      a   = 3'(i);
      row = a[2];
      col = a[1:0];
      #1;
      if (inst == 0) check($sformatf("%s.cell_a[%0d]", what, i), cell_a, m_mem[0][i]);
      else check($sformatf("%s.cell_b[%0d]", what, i), cell_b, m_mem[1][i]);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row  = 1'b0;
    col  = 2'd0;
    m_done[0] = 0;
    m_done[1] = 0;
    @(negedge clk);
    do_reset(3);

    // Reset idle
    repeat (200) @(negedge clk);
    check_status(0, "idle");
    check_status(1, "idle");
    check_cells(0, "idle");
    check_cells(1, "idle");

    // Parity error on the odd-parity instance
    send_frame(1, 8'h03, 1'b0, 1'b1);
    check_status(1, "par_err");
    check_cells(1, "par_err");

    // Full matrix, even parity, bytes 1..8
    for (int i = 1; i <= 8; i++) send_frame(0, 8'(i), 1'b1, 1'b1);
    check_status(0, "full");
    check_cells(0, "full");

    // False start: low for half a bit minus one cycle
    set_rx(0, 1'b0);
    repeat (B / 2 - 1) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (3 * B) @(negedge clk);
    check_status(0, "false_start");
    send_frame(0, 8'hC3, 1'b1, 1'b1);
    check_status(0, "after_false");
    check_cells(0, "after_false");

    // Stop error, then eight good frames to wrap the index
    send_frame(0, 8'h5A, 1'b1, 1'b0);
    check_status(0, "stop_err");
    for (int i = 0; i < 8; i++) send_frame(0, 8'($urandom), 1'b1, 1'b1);
    check_status(0, "wrap");
    check_cells(0, "wrap");

    // Random good and bad frames on the odd-parity instance
    for (int i = 0; i < 10; i++) begin
      send_frame(1, 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      if (i % 4 == 3) check_status(1, "rand_b");
    end
    check_status(1, "rand_b_end");
    check_cells(1, "rand_b_end");

    // Reset during the data bits of the third frame
    send_frame(0, 8'($urandom), 1'b1, 1'b1);
    send_frame(0, 8'($urandom), 1'b1, 1'b1);
    drive_bit(0, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(0, 1'($urandom));
    do_reset(1);
    check_status(0, "mid_rst");
    check_status(1, "mid_rst");
    check_cells(0, "mid_rst");
    check_cells(1, "mid_rst");
    for (int i = 0; i < 8; i++) send_frame(0, 8'($urandom), 1'b1, 1'b1);
    check_status(0, "post_rst");
    check_cells(0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_matrix.md
# uart_rx_matrix

Receive-side stage of the UART matrix link. Deserialises frames from the serial line driven by the transmitter, checks start/parity/stop bits, and stores each received byte into a 2×4 cell matrix in arrival order. The stored cells are read back by row/column through `r_cell`. `r_busy` is high while a matrix transfer is in progress.

## Interface
- `W`, 8: data bits per frame (LSB first).
- `PAR`, 0: parity mode.
  - 0: none.
  - 1: odd.
  - 2: even.
  - 3: treated as 0.
- `BAUD_DIV`, 4: `clk` cycles per bit. Must be even and ≥ 4.

- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line, idle high.
- `row`  in  1  read row select.
- `col`  in  [0:1]  read column select.
- `r_cell`  out  [W-1:0]  cell at `{row,col}`. Combinational read.
- `r_busy`  out  1  matrix reception in progress.
- `done`  out  1  one-cycle pulse when cell 7 has been stored.
- `err`  out  1  sticky parity/stop error. Behaviour set by the macro in Configuration.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser (reset value 1). The FSM sees `rx_s`, delayed 2 cycles.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rx_s`==0 → START, baud counter cleared.
  - START: after `BAUD_DIV/2` cycles, sample `rx_s`. If 0 → DATA. If 1 → IDLE (false start, nothing stored, index unchanged).
  - DATA: sample every `BAUD_DIV` cycles. Shift into bit `W-1` downward, so LSB arrives first. After `W` samples → PARITY if `PAR`∈{1,2}, else STOP.
  - PARITY: one sample. Expected bit is XOR of data for even; inverted XOR for odd.
  - STOP: one sample, expected 1. On the cycle after the stop sample: write the byte to `mem[idx]`, `idx` += 1, → IDLE.
- **Write order and wrap:**
  - `idx` is 3 bits and maps to `{row,col}`: 0..3 are row 0, col 0..3; 4..7 are row 1, col 0..3.
  - The write at `idx`==7 wraps `idx` to 0, pulses `done`, and deasserts `r_busy`.
- **`r_busy`:** set on the START→DATA transition when `idx`==0. Cleared with the cell-7 write. A false start never sets it.
- **Bad frames:** the cell is stored even with a parity or stop error. Matrix order is preserved.
- **Reset:** `rst` at any time, including mid-frame, returns to IDLE and sets:
  - `idx`=0;
  - all 8 cells = 0;
  - `r_busy`=0, `done`=0, `err`=0;
  - shift register = 0, synchroniser = 1.
- **Write/read collision:** a read of the cell being written in the same cycle returns the old value. The new value appears the next cycle.

## Timing
- Frame length: (2 + `W` + (`PAR`∈{1,2})) × `BAUD_DIV` cycles nominal.
- Bit sample points, relative to the falling edge of `rx`:
  - start bit at 2 + `BAUD_DIV/2`;
  - data bit k at 2 + `BAUD_DIV/2` + (k+1)·`BAUD_DIV`.
- Store latency: the cell is visible on `r_cell` 1 cycle after the stop sample.
- `done` rises in the same cycle as the cell-7 store and stays high for exactly 1 cycle.
- Back-to-back frames: a start edge arriving in the store cycle is detected in IDLE on the next cycle. Its sample points shift by at most 1 cycle, which is tolerated by mid-bit sampling.
- Reset value of every output is 0. `r_cell` reads 0 after reset.

## Configuration
- `UART_RX_ERR_EN` defined:
  - parity mismatch or stop bit 0 sets `err`;
  - `err` stays set until `rst` or the next `r_busy` rise.
- Not defined: no checking logic is compiled; `err` is tied 0. Frames are otherwise handled identically.

## Structure
- Shared package `uart_pkg` holds:
  - parity constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2;
  - `ROWS`=2, `COLS`=4;
  - FSM state encoding, shared with the transmitter.
- Sub-module `uart_rx_sync`: the 2-flop synchroniser, reset to 1.
- The baud counter and FSM stay inline.

## Test plan
- **Reset idle:** `rst` pulse, `rx`=1 for 200 cycles → `r_busy`=0, `done`=0, and all 8 cells read 0.
- **Full matrix, even parity:** `PAR`=2, `BAUD_DIV`=4. Send bytes 1..8 with correct even parity → cells read 1,2,3,4 / 5,6,7,8. `done` pulses once. `r_busy` falls with it. `err`=0.
- **False start:** `rx` low for 1 bit-half minus 1 cycle, then high → state returns to IDLE, `idx` stays 0, `r_busy` never rises.
- **Parity error:** `PAR`=1. Send 0x03 with parity bit 0 (odd expects 1) → cell 0 = 0x03. `err`=1 with `UART_RX_ERR_EN` defined, 0 without.
- **Stop error and wrap:**
  - Send 0x5A with stop bit 0 → cell stored and `err` set.
  - Then send 8 more good frames → `idx` wraps, cell 0 is overwritten, and `err` clears when `r_busy` rises.
- **Reset mid-frame:** assert `rst` during DATA of frame 3 → all cells 0 and `idx`=0 next cycle. The following full matrix is received correctly.
